// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeating it
// a requested number of times with optional idle gaps between repetitions.
module pattern_tx #(
    parameter int unsigned PAT_W   = 8,
    parameter int unsigned REP_W   = 4,
    parameter int unsigned GAP_CYC = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [PAT_W-1:0]             pat_i,
    input  logic [$clog2(PAT_W+1)-1:0]   len_i,
    input  logic [REP_W-1:0]             rep_i,
    output logic                         val_o,
    output logic                         vld_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int unsigned LEN_W = $clog2(PAT_W + 1);
    localparam int unsigned IDX_W = $clog2(PAT_W);
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [LEN_W-1:0]   r_len;
    logic [REP_W-1:0]   r_rep;
    logic [IDX_W-1:0]   r_idx;
    logic [GAP_W-1:0]   r_gap;
    logic               r_val;
    logic               r_vld;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [PAT_W-1:0]   w_pat_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [REP_W-1:0]   w_rep_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic               w_val_nxt;
    logic               w_vld_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [LEN_W-1:0]   w_len_in;
    logic [REP_W-1:0]   w_rep_in;
    logic [IDX_W-1:0]   w_top_in;
    logic [IDX_W-1:0]   w_top;

    // Argument normalisation at start acceptance; out-of-range lengths mean a full pattern
    always_comb begin
        w_len_in = len_i;
        if ((len_i == '0) || (len_i > LEN_W'(PAT_W))) begin
            w_len_in = LEN_W'(PAT_W);
        end
        w_rep_in = (rep_i == '0) ? REP_W'(1) : rep_i;
        w_top_in = IDX_W'(w_len_in - LEN_W'(1));
        w_top    = IDX_W'(r_len - LEN_W'(1));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_rep   <= '0;
            r_idx   <= '0;
            r_gap   <= '0;
            r_val   <= 1'b0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_len   <= w_len_nxt;
            r_rep   <= w_rep_nxt;
            r_idx   <= w_idx_nxt;
            r_gap   <= w_gap_nxt;
            r_val   <= w_val_nxt;
            r_vld   <= w_vld_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and next-output logic; r_idx is the index of the bit currently on val_o
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_len_nxt   = r_len;
        w_rep_nxt   = r_rep;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap;
        w_val_nxt   = 1'b0;
        w_vld_nxt   = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_pat_nxt   = pat_i;
                    w_len_nxt   = w_len_in;
                    w_rep_nxt   = w_rep_in;
                    w_idx_nxt   = w_top_in;
                    w_val_nxt   = pat_i[w_top_in];
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (r_idx != '0) begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                    w_val_nxt = r_pat[r_idx - IDX_W'(1)];
                    w_vld_nxt = 1'b1;
                end else if (r_rep > REP_W'(1)) begin
                    w_rep_nxt = r_rep - REP_W'(1);
                    if (GAP_CYC == 0) begin
                        w_idx_nxt = w_top;
                        w_val_nxt = r_pat[w_top];
                        w_vld_nxt = 1'b1;
                    end else begin
                        w_gap_nxt   = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
                        w_state_nxt = S_GAP;
                    end
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            S_GAP: begin
                if (r_gap == '0) begin
                    w_idx_nxt   = w_top;
                    w_val_nxt   = r_pat[w_top];
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign val_o  = r_val;
    assign vld_o  = r_vld;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule
